mem_access_ctrl: RTL and testbench

- Sequences single-byte reads and writes between the memory-register stage (MAR/MBR address adder, MDR) and the image data RAM.
- Takes the 17-bit byte address and the MDR write byte, drives a synchronous single-port RAM with configurable read latency, and returns the read byte together with a load strobe for the MDR.
- Shields the control unit from RAM timing with a busy/done handshake and flags out-of-range addresses.

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 87 ++++++++
 tb/tb_mem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-side signals of the memory access controller.
// The control unit and RAM model sit on the master side; the controller uses the slave modport.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              err_clr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              addr_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, err_clr, ram_rdata,
        output busy, done, rdata, rdata_valid, addr_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_rd, req_wr, req_addr, req_wdata, err_clr, ram_rdata,
        input  busy, done, rdata, rdata_valid, addr_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-byte read/write sequencer between the MAR/MDR stage and the image RAM.
// Latency: write/error done 2 cycles after accept, read done 2+READ_LATENCY cycles after accept.
// Backpressure: busy high while an access is in flight; requests seen while busy are dropped.
module mem_access_ctrl #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int MEM_DEPTH    = 81920
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [31:0] DEPTH32 = 32'(MEM_DEPTH);
    localparam logic [2:0]  LAT     = 3'(READ_LATENCY);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic              op_wr_q;
    logic              ok_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic in_range;
    logic accept;
    logic conflict;

    assign in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < DEPTH32);
    assign accept   = (state_q == S_IDLE) && (bus.req_rd ^ bus.req_wr);
    assign conflict = (state_q == S_IDLE) && bus.req_rd && bus.req_wr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = (in_range && !op_wr_q) ? S_WAIT : S_DONE;
            S_WAIT:  if (cnt_q == 3'd1) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                op_wr_q <= bus.req_wr;
            end
            if (state_q == S_ISSUE) begin
                ok_q <= in_range;
                if (in_range && !op_wr_q) cnt_q <= LAT;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Capture on the cycle the RAM pipeline presents the data.
            if (state_q == S_WAIT && cnt_q == 3'd1) rdata_q <= bus.ram_rdata;
            // A fresh error outranks a simultaneous clear.
            if (conflict || (state_q == S_ISSUE && !in_range)) err_q <= 1'b1;
            else if (bus.err_clr)                               err_q <= 1'b0;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.rdata_valid = (state_q == S_DONE) && ok_q && !op_wr_q;
    assign bus.rdata       = rdata_q;
    assign bus.addr_err    = err_q;
    assign bus.ram_en      = (state_q == S_ISSUE) && in_range;
    assign bus.ram_we      = (state_q == S_ISSUE) && in_range && op_wr_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: two instances (read latency 1 and 3) with RAM models,
// checked against a byte-array memory model and cycle-count expectations.
module tb_mem_access_ctrl;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int DEPTH = 81920;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MEM_DEPTH(DEPTH))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .MEM_DEPTH(DEPTH))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    // stimulus
    logic          sel = 1'b0;
    logic          rd = 1'b0, wr = 1'b0, clr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    assign if_a.req_rd = rd & ~sel;
    assign if_a.req_wr = wr & ~sel;
    assign if_b.req_rd = rd & sel;
    assign if_b.req_wr = wr & sel;
    assign if_a.req_addr = addr;
    assign if_b.req_addr = addr;
    assign if_a.req_wdata = wdata;
    assign if_b.req_wdata = wdata;
    assign if_a.err_clr = clr;
    assign if_b.err_clr = clr;

    // RAM contents stored relative to a per-address background pattern
    function automatic logic [7:0] bg(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[16], 7'h15};
    endfunction

    bit   [7:0] ram_a [DEPTH];
    bit   [7:0] ram_b [DEPTH];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];

    always @(posedge clk) begin
        if (if_a.ram_en && if_a.ram_addr < DEPTH) begin
            if (if_a.ram_we) ram_a[if_a.ram_addr] <= if_a.ram_wdata ^ bg(if_a.ram_addr);
            pipe_a <= ram_a[if_a.ram_addr] ^ bg(if_a.ram_addr);
        end else begin
            pipe_a <= 8'($urandom);
        end
        if (if_b.ram_en && if_b.ram_addr < DEPTH) begin
            if (if_b.ram_we) ram_b[if_b.ram_addr] <= if_b.ram_wdata ^ bg(if_b.ram_addr);
            pipe_b[0] <= ram_b[if_b.ram_addr] ^ bg(if_b.ram_addr);
        end else begin
            pipe_b[0] <= 8'($urandom);
        end
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign if_a.ram_rdata = pipe_a;
    assign if_b.ram_rdata = pipe_b[2];

    // observed outputs of the selected instance
    logic          o_busy, o_done, o_rv, o_err, o_en, o_we;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_raddr;
    assign o_busy  = sel ? if_b.busy        : if_a.busy;
    assign o_done  = sel ? if_b.done        : if_a.done;
    assign o_rv    = sel ? if_b.rdata_valid : if_a.rdata_valid;
    assign o_err   = sel ? if_b.addr_err    : if_a.addr_err;
    assign o_en    = sel ? if_b.ram_en      : if_a.ram_en;
    assign o_we    = sel ? if_b.ram_we      : if_a.ram_we;
    assign o_rdata = sel ? if_b.rdata       : if_a.rdata;
    assign o_raddr = sel ? if_b.ram_addr    : if_a.ram_addr;

    // reference model state
    logic [7:0] mm [int];
    logic [7:0] exp_rdata [2];
    bit         err_m [2];

    function automatic logic [7:0] model_rd(input bit s, input logic [AW-1:0] a);
        int k;
        k = int'({s, a});
        return mm.exists(k) ? mm[k] : bg(a);
    endfunction

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic access(input bit s, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
        int  done_cyc, en_cnt, exp_done;
        bit  err, bad_we, busy_gap, bad_addr, rv, late_busy;
        logic [DW-1:0] rdat;
        logic          aerr;
        done_cyc = 0; en_cnt = 0; bad_we = 0; busy_gap = 0; bad_addr = 0; rv = 0; late_busy = 0;
        rdat = '0; aerr = 1'b0;
        err = (a >= DEPTH);
        @(negedge clk);
        sel = s; rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (o_we && !o_en) bad_we = 1;
            if (o_en) begin
                en_cnt++;
                if (o_raddr !== a || o_we !== w) bad_addr = 1;
            end
            if (!o_busy) busy_gap = 1;
            if (cyc == 1) begin
                rd = poke ? ~r : 1'b0;
                wr = 1'b0;
                addr = a ^ 17'h40;
            end else begin
                rd = 1'b0;
            end
            if (o_done) begin
                done_cyc = cyc; rv = o_rv; rdat = o_rdata; aerr = o_err;
                break;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (o_busy || o_en) late_busy = 1;
        end
        if (err) err_m[s] = 1;
        else if (w) mm[int'({s, a})] = d;
        else exp_rdata[s] = model_rd(s, a);
        exp_done = (err || w) ? 2 : (s ? 5 : 3);
        chk("done_cycle", done_cyc, exp_done);
        chk("ram_en_pulses", en_cnt, err ? 0 : 1);
        chk("rdata_valid", rv, (!err && r) ? 1 : 0);
        chk("rdata", rdat, exp_rdata[s]);
        chk("addr_err", aerr, err_m[s]);
        chk("busy_during_access", busy_gap, 0);
        chk("ram_addr_we", bad_addr | bad_we, 0);
        chk("idle_after_done", late_busy, 0);
    endtask

    task automatic conflict(input bit s);
        bit seen;
        seen = 0;
        @(negedge clk);
        sel = s; rd = 1'b1; wr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (o_busy || o_en) seen = 1;
        end
        rd = 1'b0; wr = 1'b0;
        err_m[s] = 1;
        chk("conflict_no_access", seen, 0);
        chk("conflict_addr_err", o_err, 1);
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        err_m[0] = 0; err_m[1] = 0;
        chk("err_clr_a", if_a.addr_err, 0);
        chk("err_clr_b", if_b.addr_err, 0);
    endtask

    task automatic reset_mid_read();
        int dones;
        dones = 0;
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = 17'h100;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        chk("in_wait_busy", if_b.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {if_b.busy, if_b.done, if_b.rdata_valid, if_b.addr_err,
                            if_b.ram_en, if_b.ram_we}, 0);
        chk("rst_ram_addr", if_b.ram_addr, 0);
        chk("rst_ram_wdata", if_b.ram_wdata, 0);
        chk("rst_rdata", if_b.rdata, 0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        err_m[0] = 0; err_m[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (if_b.done || if_b.busy) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        access(1, 1, 0, 17'h100, 8'h00, 0);
    endtask

    task automatic back_to_back();
        logic [AW-1:0] al [4];
        int k, cyc;
        for (int i = 0; i < 4; i++) al[i] = AW'($urandom_range(32'h300, 32'h31F));
        k = 0; cyc = 0;
        @(negedge clk);
        sel = 1'b0; rd = 1'b1; wr = 1'b0; addr = al[0];
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (o_done) begin
                exp_rdata[0] = model_rd(0, al[k]);
                chk("b2b_done_cycle", cyc, 3 + 4 * k);
                chk("b2b_rdata", o_rdata, exp_rdata[0]);
                chk("b2b_rdata_valid", o_rv, 1);
                k++;
                if (k < 4) addr = al[k];
                else rd = 1'b0;
            end
        end
        rd = 1'b0;
        chk("b2b_count", k, 4);
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] bnd [5];
        logic [AW-1:0] a;
        bnd[0] = 17'd81919; bnd[1] = 17'd81920; bnd[2] = 17'd81921;
        bnd[3] = 17'h1FFFF; bnd[4] = 17'h0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        err_m[0] = 0; err_m[1] = 0;

        #1;
        chk("reset_a", {if_a.busy, if_a.done, if_a.rdata_valid, if_a.addr_err,
                        if_a.ram_en, if_a.ram_we}, 0);
        chk("reset_b_rdata", if_b.rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        access(0, 0, 1, 17'h00010, 8'h5A, 0);
        access(0, 1, 0, 17'h00010, 8'h00, 0);
        access(1, 0, 1, 17'h00222, 8'hC3, 0);
        access(1, 1, 0, 17'h00222, 8'h00, 0);
        access(0, 1, 0, 17'd81919, 8'h00, 0);
        access(0, 1, 0, 17'd81920, 8'h00, 0);
        clear_err();
        conflict(0);
        clear_err();
        access(0, 1, 0, 17'h00010, 8'h00, 1);
        access(1, 0, 1, 17'h00011, 8'h77, 1);
        reset_mid_read();
        back_to_back();

        for (int n = 0; n < 60; n++) begin
            bit s, w;
            s = 1'($urandom);
            w = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                conflict(s);
            end else begin
                a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 4)]
                                                : AW'($urandom_range(32'h300, 32'h31F));
                access(s, ~w, w, a, 8'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
